// File: rtl/mem_if_pkg.sv
// rtl/mem_if_pkg.sv - shared request layout and arbiter FSM encoding
//
// Purpose: field positions of the 25-bit cache memory request and the
//          state encoding of the dual memory arbiter.
// Ports:   none (package).
package mem_if_pkg;

    localparam int REQ_WIDTH     = 25;
    localparam int REQ_WRITE_BIT = 24;
    localparam int REQ_DATA_MSB  = 23;
    localparam int REQ_DATA_LSB  = 16;
    localparam int REQ_ADDR_MSB  = 15;
    localparam int REQ_ADDR_LSB  = 0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        RESPOND = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-requester round-robin with per-port arming
//
// Purpose: picks one of two requesters, alternating on ties, and masks a
//          requester whose held request has already been answered.
// Ports:   clock, reset (async active-low)
//          req[1:0]     request levels from the two ports
//          enable       a grant may be taken this cycle
//          done[1:0]    response pulse issued for port N this cycle
//          grant_valid  some port is granted this cycle
//          grant_port   granted port index
module rr_arbiter2 (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       enable,
    input  logic [1:0] done,
    output logic       grant_valid,
    output logic       grant_port
);

    logic       last_grant;
    logic [1:0] armed;
    logic [1:0] eligible;

    assign eligible = req & armed;

    always_comb begin
        grant_valid = enable && (eligible != 2'b00);
        grant_port  = 1'b0;
        if (eligible == 2'b11) begin
            grant_port = ~last_grant;
        end else if (eligible[1]) begin
            grant_port = 1'b1;
        end
    end

    // last_grant only moves on a genuine tie, so a port served alone does
    // not lose its turn at the next contention.
    // A low request level always re-arms, even in the cycle of its own
    // response, because the cache has already let go of that request.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            last_grant <= 1'b1;
            armed      <= 2'b11;
        end else begin
            if (enable && eligible == 2'b11) begin
                last_grant <= grant_port;
            end
            if (!req[0]) begin
                armed[0] <= 1'b1;
            end else if (done[0]) begin
                armed[0] <= 1'b0;
            end
            if (!req[1]) begin
                armed[1] <= 1'b1;
            end else if (done[1]) begin
                armed[1] <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/dual_memory_arbiter.sv
// rtl/dual_memory_arbiter.sv - serialises two cache ports onto one word memory
//
// Purpose: services byte read/write requests from two cache ports against a
//          shared 16-bit word memory, returns the whole word, and sends a
//          snoop-invalidate to the peer port after every write.
// Ports:   clock, reset (async active-low)
//          memory_request_N / memory_request_ready_N    request from port N
//          memory_response_N / memory_response_ready_N  word + 1-cycle pulse
//          snoop_valid_N, snoop_addr                    invalidate for port N
//          mem_req/we/addr/wdata/wmask, mem_ack, mem_rdata  backing memory
module dual_memory_arbiter
    import mem_if_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8,
    parameter int WORD_WIDTH = 16
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic [DATA_WIDTH+ADDR_WIDTH:0]     memory_request_0,
    input  logic                               memory_request_ready_0,
    input  logic [DATA_WIDTH+ADDR_WIDTH:0]     memory_request_1,
    input  logic                               memory_request_ready_1,
    output logic [WORD_WIDTH-1:0]              memory_response_0,
    output logic                               memory_response_ready_0,
    output logic [WORD_WIDTH-1:0]              memory_response_1,
    output logic                               memory_response_ready_1,
    output logic                               snoop_valid_0,
    output logic                               snoop_valid_1,
    output logic [ADDR_WIDTH-2:0]              snoop_addr,
    output logic                               mem_req,
    output logic                               mem_we,
    output logic [ADDR_WIDTH-2:0]              mem_addr,
    output logic [WORD_WIDTH-1:0]              mem_wdata,
    output logic [1:0]                         mem_wmask,
    input  logic                               mem_ack,
    input  logic [WORD_WIDTH-1:0]              mem_rdata
);

    arb_state_t state, state_nx;

    logic [REQ_WIDTH-1:0]  cmd;
    logic                  cmd_port;
    logic [WORD_WIDTH-1:0] rdata_q;
    logic                  grant_valid;
    logic                  grant_port;
    logic [1:0]            done;

    logic                  cmd_write;
    logic [DATA_WIDTH-1:0] cmd_data;
    logic [ADDR_WIDTH-1:0] cmd_addr;

    assign cmd_write = cmd[REQ_WRITE_BIT];
    assign cmd_data  = cmd[REQ_DATA_MSB:REQ_DATA_LSB];
    assign cmd_addr  = cmd[REQ_ADDR_MSB:REQ_ADDR_LSB];

    assign done = {(state == RESPOND) &&  cmd_port,
                   (state == RESPOND) && !cmd_port};

    rr_arbiter2 u_arb (
        .clock       (clock),
        .reset       (reset),
        .req         ({memory_request_ready_1, memory_request_ready_0}),
        .enable      (state == IDLE),
        .done        (done),
        .grant_valid (grant_valid),
        .grant_port  (grant_port)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // The command latch frees the cache to drop its request mid-transfer;
    // the transfer is finished from the latched copy regardless.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cmd      <= '0;
            cmd_port <= 1'b0;
            rdata_q  <= '0;
        end else begin
            if (grant_valid) begin
                cmd      <= grant_port ? memory_request_1 : memory_request_0;
                cmd_port <= grant_port;
            end
            if (state == ISSUE && mem_ack) begin
                rdata_q <= mem_rdata;
            end
        end
    end

    // Every output is decoded from state so reset clears them all at once.
    always_comb begin
        state_nx                = state;
        mem_req                 = 1'b0;
        mem_we                  = 1'b0;
        mem_addr                = '0;
        mem_wdata               = '0;
        mem_wmask               = 2'b00;
        memory_response_0       = '0;
        memory_response_ready_0 = 1'b0;
        memory_response_1       = '0;
        memory_response_ready_1 = 1'b0;
        snoop_valid_0           = 1'b0;
        snoop_valid_1           = 1'b0;
        snoop_addr              = '0;
        case (state)
            IDLE: begin
                if (grant_valid) begin
                    state_nx = ISSUE;
                end
            end
            ISSUE: begin
                mem_req   = 1'b1;
                mem_we    = cmd_write;
                mem_addr  = cmd_addr[ADDR_WIDTH-1:1];
                mem_wdata = {cmd_data, cmd_data};
                mem_wmask = {cmd_addr[0], ~cmd_addr[0]};
                if (mem_ack) begin
                    state_nx = RESPOND;
                end
            end
            RESPOND: begin
                if (cmd_port) begin
                    memory_response_ready_1 = 1'b1;
                    memory_response_1       = rdata_q;
                end else begin
                    memory_response_ready_0 = 1'b1;
                    memory_response_0       = rdata_q;
                end
                if (cmd_write) begin
                    snoop_valid_0 = cmd_port;
                    snoop_valid_1 = ~cmd_port;
                    snoop_addr    = cmd_addr[ADDR_WIDTH-1:1];
                end
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_dual_memory_arbiter.sv
// tb/tb_dual_memory_arbiter.sv - self-checking bench for dual_memory_arbiter
module tb_dual_memory_arbiter;

    logic        clock;
    logic        reset;
    logic [24:0] memory_request_0;
    logic        memory_request_ready_0;
    logic [24:0] memory_request_1;
    logic        memory_request_ready_1;
    logic [15:0] memory_response_0;
    logic        memory_response_ready_0;
    logic [15:0] memory_response_1;
    logic        memory_response_ready_1;
    logic        snoop_valid_0;
    logic        snoop_valid_1;
    logic [14:0] snoop_addr;
    logic        mem_req;
    logic        mem_we;
    logic [14:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [1:0]  mem_wmask;
    logic        mem_ack;
    logic [15:0] mem_rdata;

    dual_memory_arbiter dut (
        .clock                   (clock),
        .reset                   (reset),
        .memory_request_0        (memory_request_0),
        .memory_request_ready_0  (memory_request_ready_0),
        .memory_request_1        (memory_request_1),
        .memory_request_ready_1  (memory_request_ready_1),
        .memory_response_0       (memory_response_0),
        .memory_response_ready_0 (memory_response_ready_0),
        .memory_response_1       (memory_response_1),
        .memory_response_ready_1 (memory_response_ready_1),
        .snoop_valid_0           (snoop_valid_0),
        .snoop_valid_1           (snoop_valid_1),
        .snoop_addr              (snoop_addr),
        .mem_req                 (mem_req),
        .mem_we                  (mem_we),
        .mem_addr                (mem_addr),
        .mem_wdata               (mem_wdata),
        .mem_wmask               (mem_wmask),
        .mem_ack                 (mem_ack),
        .mem_rdata               (mem_rdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        bit          port;
        bit          w;
        logic [7:0]  d;
        logic [15:0] a;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] mem [0:32767];
    int          checks = 0;
    int          failures = 0;
    int          ack_delay = 1;
    int          req_rises = 0;
    int          snoop0_cnt = 0;
    int          snoop1_cnt = 0;

    int          got_port[$];
    int          got_lat[$];
    logic [15:0] got_data[$];
    logic [16:0] got_snp[$];
    logic        first_we;
    logic [14:0] first_addr;
    logic [15:0] first_wdata;
    logic [1:0]  first_wmask;
    int          req_cycles;
    int          addr_moves;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Backing memory: acks after ack_delay request cycles and applies the
    // expected byte write itself (odd address = high byte).
    initial begin
        int   cnt;
        exp_t e;
        for (int i = 0; i < 32768; i++) mem[i] = 16'(i) ^ 16'hA5C3;
        mem[15'h000B] = 16'h7F10;
        mem_ack   = 1'b0;
        mem_rdata = 16'hDEAD;
        cnt       = 0;
        forever begin
            @(negedge clock);
            mem_ack   = 1'b0;
            mem_rdata = 16'hDEAD;
            if (reset && mem_req) begin
                cnt++;
                if (cnt >= ack_delay) begin
                    cnt     = 0;
                    mem_ack = 1'b1;
                    if (sb.size() > 0) begin
                        e = sb[0];
                        if (e.w) begin
                            if (e.a[0]) mem[e.a[15:1]][15:8] = e.d;
                            else        mem[e.a[15:1]][7:0]  = e.d;
                        end
                        mem_rdata = mem[e.a[15:1]];
                    end
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Per-cycle compare against the expected service order.
    initial begin
        logic prev_req;
        exp_t e;
        prev_req = 1'b0;
        forever begin
            @(negedge clock);
            if (!reset) begin
                prev_req = 1'b0;
                continue;
            end
            if (mem_req && !prev_req) req_rises++;
            prev_req = mem_req;
            if (mem_req) begin
                if (sb.size() == 0) begin
                    check("spurious_mem_req", 1, 0);
                end else begin
                    e = sb[0];
                    check("mem_we", mem_we, e.w);
                    check("mem_addr", mem_addr, e.a[15:1]);
                    check("mem_wdata", mem_wdata, {e.d, e.d});
                    check("mem_wmask", mem_wmask, {e.a[0], ~e.a[0]});
                end
            end
            check("resp_one_hot", memory_response_ready_0 & memory_response_ready_1, 0);
            if (!memory_response_ready_0) check("resp0_idle_zero", memory_response_0, 0);
            if (!memory_response_ready_1) check("resp1_idle_zero", memory_response_1, 0);
            if (memory_response_ready_0 || memory_response_ready_1) begin
                if (sb.size() == 0) begin
                    check("spurious_response", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("resp_port", memory_response_ready_1, e.port);
                    check("resp_data", e.port ? memory_response_1 : memory_response_0, mem[e.a[15:1]]);
                    check("snoop_peer", {snoop_valid_1, snoop_valid_0}, e.w ? (e.port ? 2'b01 : 2'b10) : 2'b00);
                    check("snoop_addr", snoop_addr, e.w ? e.a[15:1] : 15'h0);
                end
            end else begin
                check("snoop_idle", {snoop_valid_1, snoop_valid_0, snoop_addr}, 0);
            end
            snoop0_cnt += int'(snoop_valid_0);
            snoop1_cnt += int'(snoop_valid_1);
        end
    end

    task automatic issue(input bit port, input bit w, input logic [7:0] d, input logic [15:0] a);
        exp_t e;
        e.port = port; e.w = w; e.d = d; e.a = a;
        sb.push_back(e);
        if (port) begin
            memory_request_1       = {w, d, a};
            memory_request_ready_1 = 1'b1;
        end else begin
            memory_request_0       = {w, d, a};
            memory_request_ready_0 = 1'b1;
        end
    endtask

    // Waits for n response pulses; latency counted in cycles from the call.
    task automatic run(input int n, input int budget, input bit drop);
        int  t;
        bit  seen;
        t = 0; seen = 0; req_cycles = 0; addr_moves = 0;
        got_port.delete(); got_lat.delete(); got_data.delete(); got_snp.delete();
        while (got_port.size() < n && t < budget) begin
            @(negedge clock);
            #1;
            t++;
            if (mem_req) begin
                req_cycles++;
                if (!seen) begin
                    seen = 1; first_we = mem_we; first_addr = mem_addr;
                    first_wdata = mem_wdata; first_wmask = mem_wmask;
                end else if (mem_addr !== first_addr) begin
                    addr_moves++;
                end
            end
            if (memory_response_ready_0) begin
                got_port.push_back(0); got_lat.push_back(t);
                got_data.push_back(memory_response_0);
                got_snp.push_back({snoop_valid_1, snoop_valid_0, snoop_addr});
                if (drop) memory_request_ready_0 = 1'b0;
            end
            if (memory_response_ready_1) begin
                got_port.push_back(1); got_lat.push_back(t);
                got_data.push_back(memory_response_1);
                got_snp.push_back({snoop_valid_1, snoop_valid_0, snoop_addr});
                if (drop) memory_request_ready_1 = 1'b0;
            end
        end
        check("run_completed", got_port.size(), n);
        while (got_port.size() < n) begin
            got_port.push_back(-1); got_lat.push_back(-1);
            got_data.push_back('x); got_snp.push_back('x);
        end
        check("sb_drained", sb.size(), 0);
    endtask

    initial begin
        int          r0;
        int          s0;
        logic [16:0] snp_exp;
        reset = 1'b0;
        memory_request_0 = '0; memory_request_ready_0 = 1'b0;
        memory_request_1 = '0; memory_request_ready_1 = 1'b0;
        repeat (3) @(negedge clock);
        #1;
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_bus", {mem_we, mem_addr, mem_wmask}, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_resp", {memory_response_ready_1, memory_response_ready_0, memory_response_1, memory_response_0}, 0);
        check("rst_snoop", {snoop_valid_1, snoop_valid_0, snoop_addr}, 0);
        reset = 1'b1;
        @(negedge clock); #1;

        // single read
        ack_delay = 1;
        issue(0, 0, 8'h00, 16'h0017);
        run(1, 30, 1);
        check("t1_port", got_port[0], 0);
        check("t1_latency", got_lat[0], 2);
        check("t1_data", got_data[0], 16'h7F10);
        check("t1_mem_addr", first_addr, 15'h000B);
        check("t1_mem_we", first_we, 0);
        check("t1_no_snoop", got_snp[0], 0);
        @(negedge clock); #1;

        // write with snoop to the peer
        s0 = snoop0_cnt;
        issue(1, 1, 8'h19, 16'h0017);
        run(1, 30, 1);
        snp_exp = {2'b01, 15'h000B};
        check("t2_wmask", first_wmask, 2'b10);
        check("t2_wdata", first_wdata, 16'h1919);
        check("t2_data", got_data[0], 16'h1910);
        check("t2_snoop", got_snp[0], snp_exp);
        @(negedge clock); #1;
        check("t2_snoop_pulses", snoop0_cnt - s0, 1);

        // contention: first tie goes to port 0
        issue(0, 0, 8'h00, 16'h0040);
        issue(1, 0, 8'h00, 16'h0041);
        run(2, 40, 1);
        check("t3_first", got_port[0], 0);
        check("t3_second", got_port[1], 1);
        check("t3_spacing", got_lat[1] - got_lat[0], 3);
        check("t3_data", got_data[1], 16'hA5E3);
        @(negedge clock); #1;

        // second tie goes to port 1
        issue(1, 1, 8'h55, 16'h0040);
        issue(0, 0, 8'h00, 16'h0041);
        run(2, 40, 1);
        check("t3b_first", got_port[0], 1);
        check("t3b_second", got_port[1], 0);
        check("t3b_data", got_data[1], 16'hA555);
        @(negedge clock); #1;

        // level-held request is served once
        r0 = req_rises;
        issue(0, 0, 8'h00, 16'h0100);
        run(1, 30, 0);
        check("t4_data", got_data[0], 16'hA543);
        repeat (10) @(negedge clock);
        #1;
        check("t4_single_req", req_rises - r0, 1);
        memory_request_ready_0 = 1'b0;
        @(negedge clock); #1;
        issue(0, 0, 8'h00, 16'h0100);
        run(1, 30, 1);
        check("t4_rearm_latency", got_lat[0], 2);
        check("t4_rearm_req", req_rises - r0, 2);
        @(negedge clock); #1;

        // slow memory
        ack_delay = 5;
        issue(1, 0, 8'h00, 16'h0203);
        run(1, 40, 1);
        check("t5_latency", got_lat[0], 6);
        check("t5_req_cycles", req_cycles, 5);
        check("t5_addr_stable", addr_moves, 0);
        check("t5_data", got_data[0], 16'hA4C2);
        @(negedge clock); #1;

        // reset in the middle of ISSUE
        issue(0, 0, 8'h00, 16'h0300);
        @(negedge clock); #1;
        @(negedge clock); #1;
        check("t6_in_issue", mem_req, 1);
        reset = 1'b0;
        #1;
        check("t6_req_drop", mem_req, 0);
        check("t6_resp_zero", {memory_response_ready_1, memory_response_ready_0, memory_response_1, memory_response_0}, 0);
        sb.delete();
        memory_request_ready_0 = 1'b0;
        @(negedge clock); #1;
        reset = 1'b1;
        ack_delay = 1;
        @(negedge clock); #1;
        issue(0, 0, 8'h00, 16'h0300);
        run(1, 30, 1);
        check("t6_port", got_port[0], 0);
        check("t6_latency", got_lat[0], 2);
        check("t6_data", got_data[0], 16'hA443);
        repeat (2) @(negedge clock);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
